// File: rtl/logic_issue_unit.sv
// Initiator-side sequencer for the combinational logic unit: decodes one logic-class
// instruction, issues registered operands/control, captures the result and returns it.
module logic_issue_unit #(
  parameter int ZEXT_IMM = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic [15:0]      imm,
  output logic [31:0]      ALU_DA,
  output logic [31:0]      ALU_DB,
  output logic [1:0]       Logicctr,
  input  logic [31:0]      logic_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state, state_next;
  logic        legal;
  logic [1:0]  dec_ctr;
  logic [31:0] dec_db;
  logic [31:0] ext_imm;

  always_comb begin
    ext_imm = (ZEXT_IMM != 0) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
  end

  always_comb begin
    legal   = 1'b0;
    dec_ctr = 2'b00;
    dec_db  = rt_data;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100100: begin legal = 1'b1; dec_ctr = 2'b00; end
          6'b100101: begin legal = 1'b1; dec_ctr = 2'b01; end
          6'b100110: begin legal = 1'b1; dec_ctr = 2'b10; end
          6'b100111: begin legal = 1'b1; dec_ctr = 2'b11; end
          default:   legal = 1'b0;
        endcase
      end
      6'b001100: begin legal = 1'b1; dec_ctr = 2'b00; dec_db = ext_imm; end
      6'b001101: begin legal = 1'b1; dec_ctr = 2'b01; dec_db = ext_imm; end
      6'b001110: begin legal = 1'b1; dec_ctr = 2'b10; dec_db = ext_imm; end
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = legal ? ISSUE : RESP;
      ISSUE:   state_next = RESP;
      RESP:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags derive straight from the state register, so no extra flops.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_DA      <= '0;
      ALU_DB      <= '0;
      Logicctr    <= '0;
      out_data    <= '0;
      out_illegal <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (legal) begin
              ALU_DA   <= rs_data;
              ALU_DB   <= dec_db;
              Logicctr <= dec_ctr;
            end else begin
              out_data    <= '0;
              out_illegal <= 1'b1;
            end
          end
        end
        ISSUE: begin
          out_data    <= logic_result;
          out_illegal <= 1'b0;
          op_count    <= op_count + CNT_W'(1);
        end
        RESP: begin
          if (out_ready) out_illegal <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_issue_unit.sv
// Directed bench for logic_issue_unit: zero- and sign-extending instances, a behavioural
// logic unit, and a scoreboard of expected responses popped when out_valid appears.
module tb_logic_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [5:0]  op, funct;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic [31:0] alu_da, alu_db, alu_da2, alu_db2;
  logic [1:0]  ctr, ctr2;
  logic [31:0] lres, lres2;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_data, out_data2;
  logic        out_illegal, out_illegal2;
  logic [1:0]  op_count;
  logic [15:0] op_count2;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        legal;
    logic [31:0] data_z;
    logic [31:0] data_s;
  } exp_t;
  exp_t sb[$];

  int          exp_cnt = 0;
  logic [31:0] last_da = '0, last_db = '0;
  logic [1:0]  last_ctr = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    case (c)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign lres  = lu(alu_da, alu_db, ctr);
  assign lres2 = lu(alu_da2, alu_db2, ctr2);

  logic_issue_unit #(.ZEXT_IMM(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .ALU_DA(alu_da), .ALU_DB(alu_db), .Logicctr(ctr), .logic_result(lres),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_illegal(out_illegal), .op_count(op_count)
  );

  logic_issue_unit #(.ZEXT_IMM(0), .CNT_W(16)) dut_sx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .ALU_DA(alu_da2), .ALU_DB(alu_db2), .Logicctr(ctr2), .logic_result(lres2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_illegal(out_illegal2), .op_count(op_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bench-side decode of the instruction set, independent of the DUT internals.
  task automatic run_op(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                        input int hold);
    logic        lg;
    logic [1:0]  c;
    logic [31:0] dbz, dbs;
    exp_t        e;
    int          n;
    lg = 1'b0; c = 2'b00; dbz = rt; dbs = rt;
    if (o == 6'b000000) begin
      if (f == 6'b100100) begin lg = 1'b1; c = 2'b00; end
      if (f == 6'b100101) begin lg = 1'b1; c = 2'b01; end
      if (f == 6'b100110) begin lg = 1'b1; c = 2'b10; end
      if (f == 6'b100111) begin lg = 1'b1; c = 2'b11; end
    end else if (o == 6'b001100 || o == 6'b001101 || o == 6'b001110) begin
      lg  = 1'b1;
      c   = (o == 6'b001100) ? 2'b00 : (o == 6'b001101) ? 2'b01 : 2'b10;
      dbz = {16'h0000, im};
      dbs = {{16{im[15]}}, im};
    end
    e.legal  = lg;
    e.data_z = lg ? lu(rs, dbz, c) : 32'h0;
    e.data_s = lg ? lu(rs, dbs, c) : 32'h0;
    sb.push_back(e);

    op = o; funct = f; rs_data = rs; rt_data = rt; imm = im;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (lg) begin
      check({tag, "/ctr"}, 32'(ctr), 32'(c));
      check({tag, "/da"}, alu_da, rs);
      check({tag, "/db"}, alu_db, dbz);
      last_ctr = c; last_da = rs; last_db = dbz;
    end else begin
      check({tag, "/ctr_hold"}, 32'(ctr), 32'(last_ctr));
      check({tag, "/da_hold"}, alu_da, last_da);
      check({tag, "/db_hold"}, alu_db, last_db);
    end
    n = 1;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, 32'(n), lg ? 32'd2 : 32'd1);
    e = sb.pop_front();
    if (e.legal) exp_cnt = (exp_cnt + 1) % 4;
    check({tag, "/data"}, out_data, e.data_z);
    check({tag, "/data_sx"}, out_data2, e.data_s);
    check({tag, "/illegal"}, 32'(out_illegal), e.legal ? 32'd0 : 32'd1);
    check({tag, "/count"}, 32'(op_count), 32'(exp_cnt));
    for (int i = 0; i < hold; i++) begin
      check({tag, "/bp_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/bp_data"}, out_data, e.data_z);
      check({tag, "/bp_in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/done_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/done_illegal"}, 32'(out_illegal), 32'd0);
    check({tag, "/done_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; funct = '0; rs_data = '0; rt_data = '0; imm = '0;
    #12;
    check("rst/valid", 32'(out_valid), 32'd0);
    check("rst/count", 32'(op_count), 32'd0);
    check("rst/da", alu_da, 32'd0);
    check("rst/data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_op("xor",   6'b000000, 6'b100110, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'h0000, 0);
    run_op("ori",   6'b001101, 6'b000000, 32'h0000_0000, 32'h1111_1111, 16'h8001, 0);
    run_op("nor",   6'b000000, 6'b100111, 32'h0000_0000, 32'h0000_0000, 16'h0000, 5);
    run_op("add",   6'b000000, 6'b100000, 32'h1234_5678, 32'h9ABC_DEF0, 16'h0000, 0);
    run_op("andi",  6'b001100, 6'b111111, 32'hFFFF_FFFF, 32'h0,         16'hF00F, 0);
    run_op("and",   6'b000000, 6'b100100, 32'hAAAA_5555, 32'hFF00_FF00, 16'h0000, 2);
    run_op("nori",  6'b001111, 6'b000000, 32'h5555_5555, 32'h0,         16'h1234, 0);
    run_op("xori",  6'b001110, 6'b000000, 32'h0F0F_0F0F, 32'h0,         16'hFFFF, 0);
    run_op("or",    6'b000000, 6'b100101, 32'h1000_0001, 32'h0200_0020, 16'h0000, 1);

    // Asynchronous reset while a response is waiting.
    op = 6'b000000; funct = 6'b100111; rs_data = 32'h1234_5678; rt_data = 32'h0;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rstmid/pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid/valid", 32'(out_valid), 32'd0);
    check("rstmid/count", 32'(op_count), 32'd0);
    check("rstmid/da", alu_da, 32'd0);
    check("rstmid/ctr", 32'(ctr), 32'd0);
    check("rstmid/data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid/in_ready", 32'(in_ready), 32'd1);
    exp_cnt = 0; last_ctr = '0; last_da = '0; last_db = '0;
    @(posedge clk); #1;
    run_op("post_rst", 6'b000000, 6'b100110, 32'hDEAD_BEEF, 32'hFFFF_0000, 16'h0000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_issue_unit.md
Name: logic_issue_unit

Overview:
- Initiator-side sequencer for the datapath's combinational logic unit.
- Accepts one logic-class instruction at a time over a valid/ready handshake and decodes opcode/funct into the 2-bit logic control code.
- Drives registered operands and control to the logic unit, captures its result, and returns it over a valid/ready result handshake.
- Sits between the instruction decode stage and the logic unit in the multi-cycle execute path. Illegal operations are flagged.

Parameters:
- ZEXT_IMM, 1, 1 = immediate forms zero-extend imm; 0 = sign-extend.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction offered
- in_ready  output  1  unit can accept an instruction (high only in IDLE)
- op  input  6  instruction opcode
- funct  input  6  R-type function field
- rs_data  input  32  first source operand
- rt_data  input  32  second source operand (R-type)
- imm  input  16  immediate field (I-type)
- ALU_DA  output  32  operand A to the logic unit (registered)
- ALU_DB  output  32  operand B to the logic unit (registered)
- Logicctr  output  2  control code to the logic unit: 00 AND, 01 OR, 10 XOR, 11 NOR (registered)
- logic_result  input  32  combinational result from the logic unit
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  32  captured result (0 when illegal)
- out_illegal  output  1  accompanies out_valid; operation not decodable
- op_count  output  CNT_W  number of completed legal operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=IDLE. ALU_DA, ALU_DB, Logicctr, out_data and op_count are 0. out_valid and out_illegal are 0. in_ready=1 once rst is released.
- Decode:
  - op=000000 with funct 100100/100101/100110/100111 gives Logicctr 00/01/10/11, with DB=rt_data.
  - op=001100/001101/001110 (ANDI/ORI/XORI) gives Logicctr 00/01/10, with DB=ext(imm).
  - ext(imm) is {16'h0,imm} when ZEXT_IMM=1, else {{16{imm[15]}},imm}.
  - DA=rs_data in all legal cases.
  - Everything else is illegal, including R-type with any other funct. NORI does not exist.
- FSM: IDLE, ISSUE, RESP.
  - IDLE: in_ready=1. On in_valid at a clock edge:
    - legal op: load ALU_DA, ALU_DB, Logicctr and go to ISSUE.
    - illegal op: ALU_DA/DB/Logicctr are unchanged; load out_data=0, out_illegal=1, out_valid=1, and go to RESP.
  - ISSUE (exactly 1 cycle): logic_result is sampled at the closing edge into out_data. Set out_illegal=0, out_valid=1, increment op_count, go to RESP.
  - RESP: out_valid=1. out_data and out_illegal hold stable until out_valid&out_ready at an edge, then out_valid=0, out_illegal=0, and the state returns to IDLE.
- Latency:
  - Legal: out_valid rises 2 edges after the accepting edge.
  - Illegal: out_valid rises 1 edge after the accepting edge.
  - Back-to-back throughput is one operation per 3 cycles minimum (accept, issue, respond), since IDLE is re-entered only after the response handshake. There is no same-cycle bypass.
- Stability: in_ready=0 outside IDLE; inputs are ignored in ISSUE and RESP. ALU_DA/DB/Logicctr hold their last issued values until the next legal accept.
- Back-pressure: out_ready low holds RESP indefinitely. out_ready high while out_valid is low has no effect.
- op_count increments only on legal completion (ISSUE→RESP), not on illegal. It wraps from all-ones to 0.
- Reset mid-operation (any state): immediate return to reset values; the in-flight operation is dropped and is not counted.

Test Plan:
- Reset: assert rst mid-RESP with out_valid=1 -> out_valid=0, op_count=0, ALU_DA=0 immediately, without waiting for clk; in_ready=1 after release.
- R-type XOR: op=0, funct=100110, rs=32'hF0F0_1234, rt=32'h0FF0_FFFF, out_ready=1 -> Logicctr=10 in ISSUE; out_valid 2 edges after accept; out_data=32'hFF00_EDCB; out_illegal=0; op_count=1.
- ORI extension: op=001101, rs=0, imm=16'h8001. With ZEXT_IMM=1 -> out_data=32'h0000_8001. With ZEXT_IMM=0 -> out_data=32'hFFFF_8001.
- NOR with back-pressure: op=0, funct=100111, rs=rt=0, out_ready=0 for 5 cycles -> out_valid=1 and out_data=32'hFFFF_FFFF held for all 5 cycles; in_ready=0 throughout; completes on the first out_ready=1 edge.
- Illegal: op=0, funct=100000 (ADD) -> out_valid after 1 edge, out_illegal=1, out_data=0; Logicctr and op_count unchanged.
- Counter wrap: with CNT_W=2, 5 legal ops -> op_count sequence 1,2,3,0,1.
